// File: rtl/ball_engine.sv
// Per-frame ball engine: steps NUM_OBJ ballistic balls, tests them against the
// cursor, spawns from an LFSR and tracks score, lives and the game timer.
module ball_engine #(
  parameter int NUM_OBJ     = 8,
  parameter int COORD_W     = 11,
  parameter int VEL_W       = 6,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int HIT_R       = 25,
  parameter int LIVES       = 3,
  parameter int SPAWN_GAP   = 60,
  parameter int GAME_FRAMES = 10800,
  parameter int V_LAUNCH    = -22,
  parameter int SCORE_W     = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_frame_tick,
  input  logic                       i_cursor_valid,
  input  logic [COORD_W-1:0]         i_cursor_x,
  input  logic [COORD_W-1:0]         i_cursor_y,
  output logic [1:0]                 o_state,
  output logic [NUM_OBJ-1:0]         o_obj_active,
  output logic [NUM_OBJ*COORD_W-1:0] o_obj_x,
  output logic [NUM_OBJ*COORD_W-1:0] o_obj_y,
  output logic [SCORE_W-1:0]         o_score,
  output logic [1:0]                 o_lives,
  output logic [15:0]                o_frame_cnt,
  output logic                       o_game_over
);
  localparam int SW    = COORD_W + 2;
  localparam int DW    = 2 * (COORD_W + 1) + 1;
  localparam int CNT_W = $clog2(NUM_OBJ + 1);
  localparam int CD_W  = $clog2(SPAWN_GAP + 1);

  localparam logic signed [DW-1:0]    HIT_R2    = DW'(HIT_R * HIT_R);
  localparam logic signed [SW-1:0]    SCR_W     = SW'(SCREEN_W);
  localparam logic signed [SW-1:0]    SCR_H     = SW'(SCREEN_H);
  localparam logic signed [VEL_W-1:0] VY_MAX    = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W-1:0] VY_ONE    = VEL_W'(1);
  localparam logic signed [VEL_W-1:0] VY_LAUNCH = VEL_W'(V_LAUNCH);
  localparam logic signed [VEL_W-1:0] VX_MIN    = VEL_W'(-3);
  localparam logic [CD_W-1:0]         CD_RELOAD = CD_W'(SPAWN_GAP - 1);
  localparam logic [15:0]             LFSR_SEED = 16'hACE1;
  localparam logic [15:0]             LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_OVER = 2'd2} state_t;

  state_t                     state, state_n;
  logic                       do_tick, do_start, end_pulse, game_end;

  logic [NUM_OBJ-1:0]         active;
  logic [COORD_W-1:0]         x_q  [NUM_OBJ];
  logic [COORD_W-1:0]         y_q  [NUM_OBJ];
  logic signed [VEL_W-1:0]    vx_q [NUM_OBJ];
  logic signed [VEL_W-1:0]    vy_q [NUM_OBJ];
  logic [SCORE_W-1:0]         score;
  logic [1:0]                 lives;
  logic [15:0]                frame_cnt;
  logic [CD_W-1:0]            cooldown;
  logic [15:0]                lfsr;
  logic                       game_over;

  logic [NUM_OBJ-1:0]         hit, miss, side, spawn_sel;
  logic [COORD_W-1:0]         x_step  [NUM_OBJ];
  logic [COORD_W-1:0]         y_step  [NUM_OBJ];
  logic signed [VEL_W-1:0]    vy_step [NUM_OBJ];
  logic                       spawn;
  logic [CNT_W-1:0]           hit_cnt, miss_cnt;
  logic [SCORE_W:0]           score_sum;
  logic [SCORE_W-1:0]         score_n;
  logic [1:0]                 lives_n;
  logic [15:0]                frame_n, lfsr_n;
  logic [COORD_W-1:0]         x_spawn;
  logic signed [VEL_W-1:0]    vx_spawn;

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_PLAY:         if (i_frame_tick && game_end) state_n = S_OVER;
      S_IDLE, S_OVER: if (i_start) state_n = S_PLAY;
      default:        state_n = S_IDLE;
    endcase
  end

  always_comb begin
    do_tick   = (state == S_PLAY) && i_frame_tick;
    do_start  = ((state == S_IDLE) || (state == S_OVER)) && i_start;
    end_pulse = do_tick && game_end;
  end

  assign o_state = state;

  // ---------------- per-slot evaluation ----------------
  for (genvar k = 0; k < NUM_OBJ; k++) begin : g_slot
    logic signed [COORD_W:0] dx, dy;
    logic signed [DW-1:0]    dxe, dye, dist2;
    logic signed [SW-1:0]    xs, ys;

    assign dx    = $signed({1'b0, i_cursor_x}) - $signed({1'b0, x_q[k]});
    assign dy    = $signed({1'b0, i_cursor_y}) - $signed({1'b0, y_q[k]});
    assign dxe   = DW'(dx);
    assign dye   = DW'(dy);
    assign dist2 = dxe * dxe + dye * dye;
    assign xs    = $signed({2'b00, x_q[k]}) + SW'(vx_q[k]);
    assign ys    = $signed({2'b00, y_q[k]}) + SW'(vy_q[k]);

    // Hit outranks miss, miss outranks side exit.
    assign hit[k]     = active[k] && i_cursor_valid && (dist2 <= HIT_R2);
    assign miss[k]    = active[k] && !hit[k] && !vy_q[k][VEL_W-1] && (ys >= SCR_H);
    assign side[k]    = active[k] && !hit[k] && !miss[k] && (xs[SW-1] || (xs >= SCR_W));
    assign x_step[k]  = xs[COORD_W-1:0];
    assign y_step[k]  = ys[COORD_W-1:0];
    assign vy_step[k] = (vy_q[k] == VY_MAX) ? vy_q[k] : vy_q[k] + VY_ONE;
  end

  // ---------------- tick-wide combinational results ----------------
  always_comb begin
    hit_cnt  = '0;
    miss_cnt = '0;
    for (int k = 0; k < NUM_OBJ; k++) begin
      hit_cnt  = hit_cnt + CNT_W'(hit[k]);
      miss_cnt = miss_cnt + CNT_W'(miss[k]);
    end
  end

  // One-hot of the lowest slot that was empty at the start of the tick.
  assign spawn_sel = ~active & (active + NUM_OBJ'(1));
  assign spawn     = (cooldown == '0) && (|(~active));

  assign score_sum = {1'b0, score} + (SCORE_W+1)'(hit_cnt);
  assign score_n   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  assign lives_n   = (CNT_W'(lives) <= miss_cnt) ? 2'd0 : lives - 2'(miss_cnt);
  assign frame_n   = frame_cnt + 16'd1;
  assign game_end  = (lives_n == 2'd0) || (frame_n == 16'(GAME_FRAMES));

  assign x_spawn  = COORD_W'(64) + COORD_W'(lfsr[8:0]);
  assign vx_spawn = (lfsr[11:9] == 3'b100) ? VX_MIN : VEL_W'($signed(lfsr[11:9]));
  assign lfsr_n   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);

  // ---------------- datapath registers ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      active    <= '0;
      score     <= '0;
      lives     <= 2'd0;
      frame_cnt <= 16'd0;
      cooldown  <= '0;
      lfsr      <= LFSR_SEED;
      game_over <= 1'b0;
      for (int k = 0; k < NUM_OBJ; k++) begin
        x_q[k] <= '0; y_q[k] <= '0; vx_q[k] <= '0; vy_q[k] <= '0;
      end
    end else begin
      game_over <= end_pulse;
      if (do_start) begin
        active    <= '0;
        score     <= '0;
        lives     <= 2'(LIVES);
        frame_cnt <= 16'd0;
        cooldown  <= '0;
        for (int k = 0; k < NUM_OBJ; k++) begin
          x_q[k] <= '0; y_q[k] <= '0; vx_q[k] <= '0; vy_q[k] <= '0;
        end
      end else if (do_tick) begin
        for (int k = 0; k < NUM_OBJ; k++) begin
          if (active[k]) begin
            if (hit[k] || miss[k] || side[k]) begin
              active[k] <= 1'b0;
              x_q[k] <= '0; y_q[k] <= '0; vx_q[k] <= '0; vy_q[k] <= '0;
            end else begin
              x_q[k]  <= x_step[k];
              y_q[k]  <= y_step[k];
              vy_q[k] <= vy_step[k];
            end
          end else if (spawn && spawn_sel[k]) begin
            active[k] <= 1'b1;
            x_q[k]    <= x_spawn;
            y_q[k]    <= COORD_W'(SCREEN_H - 1);
            vx_q[k]   <= vx_spawn;
            vy_q[k]   <= VY_LAUNCH;
          end
        end
        score     <= score_n;
        lives     <= lives_n;
        frame_cnt <= frame_n;
        cooldown  <= spawn ? CD_RELOAD : ((cooldown != '0) ? cooldown - CD_W'(1) : cooldown);
        lfsr      <= lfsr_n;
      end
    end
  end

  always_comb begin
    o_obj_x = '0;
    o_obj_y = '0;
    for (int k = 0; k < NUM_OBJ; k++) begin
      o_obj_x[k*COORD_W +: COORD_W] = x_q[k];
      o_obj_y[k*COORD_W +: COORD_W] = y_q[k];
    end
  end

  assign o_obj_active = active;
  assign o_score      = score;
  assign o_lives      = lives;
  assign o_frame_cnt  = frame_cnt;
  assign o_game_over  = game_over;
endmodule

// File: doc/ball_engine.md
Name: ball_engine

Overview:
- Parametrised per-frame object engine for the slicing game. It holds NUM_OBJ ballistic balls and steps their physics once per video frame.
- It tests each ball against the tracked cursor (true 2-D radius), spawns new balls from an LFSR, and keeps score, lives and a game timer.
- It sits between the cursor tracker and the VGA compositor. It outputs registered object state only; drawing is done downstream.

Parameters:
- NUM_OBJ, 8, number of ball slots.
- COORD_W, 11, coordinate width (unsigned pixels).
- VEL_W, 6, velocity width (signed two's complement).
- SCREEN_W, 640, visible width.
- SCREEN_H, 480, visible height.
- HIT_R, 25, hit radius in pixels.
- LIVES, 3, lives at game start.
- SPAWN_GAP, 60, frames between spawns.
- GAME_FRAMES, 10800, game length in frames.
- V_LAUNCH, -22, initial vy at spawn.
- SCORE_W, 16, score width.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  start/restart request (level, sampled each cycle)
- i_frame_tick  in  1  one-cycle pulse per frame end
- i_cursor_valid  in  1  cursor coordinates valid this frame
- i_cursor_x  in  COORD_W  cursor x
- i_cursor_y  in  COORD_W  cursor y
- o_state  out  2  0=IDLE, 1=PLAY, 2=OVER
- o_obj_active  out  NUM_OBJ  slot occupied
- o_obj_x  out  NUM_OBJ*COORD_W  packed x, slot k at [k*COORD_W +: COORD_W]
- o_obj_y  out  NUM_OBJ*COORD_W  packed y, same packing
- o_score  out  SCORE_W  balls hit
- o_lives  out  2  remaining lives
- o_frame_cnt  out  16  frames elapsed in PLAY
- o_game_over  out  1  one-cycle pulse on PLAY->OVER

Behaviour:
- Reset (i_clk edge with i_rst=1; overrides everything, including mid-game):
  - state=IDLE; all slots inactive; x=y=vx=vy=0.
  - score=0, lives=0, frame_cnt=0, spawn cooldown=0, o_game_over=0, LFSR=16'hACE1.
- IDLE/OVER:
  - i_start=1 -> PLAY next cycle; lives=LIVES, score=0, frame_cnt=0, cooldown=0, all slots cleared.
  - LFSR is not reseeded.
- PLAY:
  - i_start is ignored.
  - Nothing changes except on cycles with i_frame_tick=1.
  - On such a tick, all NUM_OBJ slots are evaluated in parallel from current registers. Results are visible on outputs the next cycle (latency 1).
- Per active slot k, each tick, in priority order:
  1. Hit: requires i_cursor_valid=1. dx=cursor_x-x and dy=cursor_y-y, computed signed at COORD_W+1 bits. If dx*dx+dy*dy <= HIT_R*HIT_R, the slot is cleared and counts as a hit. No physics step is applied.
  2. Miss: vy >= 0 and y+vy >= SCREEN_H (signed, COORD_W+2 bits). The slot is cleared and counts as a miss.
  3. Side exit: x+vx < 0 or >= SCREEN_W. The slot is cleared, with no penalty.
  4. Otherwise: x+=vx, y+=vy (signed add, truncated to COORD_W), and vy+=1, saturating at +(2^(VEL_W-1)-1). vx is unchanged.
- Score and lives:
  - score += number of hits this tick, saturating at all-ones.
  - lives -= number of misses this tick, saturating at 0.
- Spawn:
  - If cooldown==0 and at least one slot was inactive at the start of the tick, the lowest-index inactive slot is loaded and cooldown=SPAWN_GAP-1.
  - Otherwise cooldown decrements if nonzero.
  - Slots freed in this same tick are not reusable until the next tick.
  - Spawn values: x = 64 + LFSR[8:0] (range 64..575); y = SCREEN_H-1; vx = sign-extended LFSR[11:9] clamped to -3..+3 (value -4 becomes -3); vy = V_LAUNCH.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11.
  - Advances once per PLAY tick, after its value is used for spawn.
- Timer and end of game:
  - frame_cnt increments each PLAY tick.
  - If, after this tick's updates, lives==0 or frame_cnt==GAME_FRAMES, then state=OVER and o_game_over=1 for exactly one cycle.
  - Ball slots freeze in OVER and remain visible.
- Simultaneous events: hit beats miss on the same slot; multiple hits and misses in one tick are all counted.

Test Plan:
- Reset then i_start=1, first tick with i_cursor_valid=0 -> state=PLAY, lives=3, slot0 active, y=479, vy=-22, x=64+(0xACE1&0x1FF)=289; vx = sext(0xACE1[11:9]=3'b110) = -2.
- Next tick -> slot0 y=457, vy=-21, x=287; cooldown blocks a second spawn until tick 61, when slot1 spawns.
- Cursor placed at slot0 (x+15, y+20), dist²=625 -> that slot is cleared and score=1. At (x+18, y+18), dist²=648 -> no hit.
- Let one ball fall (vy>=0, y+vy>=480) with cursor invalid -> lives 3->2, slot cleared. Force three misses -> lives=0, o_game_over pulses once, state=OVER.
- Same tick: slot0 hit and slot1 miss -> score+1, lives-1. Cursor inside a falling ball that would also exit -> counts as a hit only.
- Run 10800 ticks with no misses -> OVER on tick 10800. Assert i_rst mid-PLAY -> next cycle all outputs equal reset values; i_start during PLAY has no effect.
